// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_pkg
// Brief   : Shared constants and capture-state encoding for the UART RX path.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   localparam int         UART_DATA_W  = 8;
   localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

   typedef enum logic [1:0] {
      CAP_IDLE = 2'd0,
      CAP_ACK  = 2'd1,
      CAP_WAIT = 2'd2
   } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
//------------------------------------------------------------------------------
// Module  : uart_byte_fifo
// Brief   : First-word-fall-through synchronous byte FIFO with occupancy count.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [UART_DATA_W-1:0] push_data,
   input  logic                   pop,
   output logic [UART_DATA_W-1:0] head_data,
   output logic [ADDR_W:0]        count,
   output logic                   full,
   output logic                   empty
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [UART_DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]      wr_ptr;
   logic [ADDR_W-1:0]      rd_ptr;
   logic                   do_push;
   logic                   do_pop;

   assign full      = (count == DEPTH_CNT);
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr];

   // Storage is deliberately left out of reset; only the bookkeeping clears.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_fifo
// Brief   : Captures UART receiver bytes with an RDN handshake into a FWFT FIFO.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [UART_DATA_W-1:0] rx_data,
   input  logic                   rx_ready,
   output logic                   rx_rdn,
   output logic [UART_DATA_W-1:0] m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [ADDR_W:0]        count,
   output logic                   full,
   output logic                   empty,
   output logic                   overrun,
   output logic [7:0]             drop_cnt,
   input  logic                   clr_ovr
);

   cap_state_t state;
   logic       capture;
   logic       push;
   logic       drop;
   logic       pop;

   // A byte is taken only on entry from IDLE, so a held RX_READY yields one push.
   assign capture = (state == CAP_IDLE) && rx_ready;
   assign push    = capture && !full;
   assign drop    = capture && full;
   assign m_valid = !empty;
   assign pop     = m_valid && m_ready;

   uart_byte_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (rx_data),
      .pop       (pop),
      .head_data (m_data),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= CAP_IDLE;
         rx_rdn <= 1'b1;
      end else begin
         case (state)
            CAP_IDLE: begin
               rx_rdn <= 1'b1;
               if (rx_ready) begin
                  state  <= CAP_ACK;
                  rx_rdn <= 1'b0;
               end
            end
            CAP_ACK: begin
               state  <= CAP_WAIT;
               rx_rdn <= 1'b1;
            end
            CAP_WAIT: begin
               rx_rdn <= 1'b1;
               if (!rx_ready) begin
                  state <= CAP_IDLE;
               end
            end
            default: begin
               state  <= CAP_IDLE;
               rx_rdn <= 1'b1;
            end
         endcase
      end
   end

   // A drop coinciding with a clear restarts the tally at one.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overrun <= 1'b1;
         if (clr_ovr) begin
            drop_cnt <= 8'd1;
         end else if (drop_cnt != DROP_CNT_MAX) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end else if (clr_ovr) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_rx_fifo
// Brief   : Directed self-checking bench for uart_rx_fifo.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_rdn;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       overrun;
   logic [7:0] drop_cnt;
   logic       clr_ovr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .DEPTH  (16),
      .ADDR_W (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .rx_rdn   (rx_rdn),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .overrun  (overrun),
      .drop_cnt (drop_cnt),
      .clr_ovr  (clr_ovr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Receiver model: hold the byte until RDN is seen low, then release.
   task automatic send_byte(input logic [7:0] b);
      logic seen;
      seen     = 1'b0;
      rx_data  = b;
      rx_ready = 1'b1;
      for (int k = 0; k < 8 && !seen; k++) begin
         tick();
         if (rx_rdn == 1'b0) seen = 1'b1;
      end
      chk("rdn_seen", {31'd0, seen}, 32'd1);
      rx_ready = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int lows;
      rst      = 1'b1;
      rx_data  = 8'h00;
      rx_ready = 1'b0;
      m_ready  = 1'b0;
      clr_ovr  = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset values
      chk("rst_rdn", rx_rdn, 1);
      chk("rst_valid", m_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_drop", drop_cnt, 0);

      // Single byte: latency and one-cycle RDN pulse
      rx_data  = 8'h5A;
      rx_ready = 1'b1;
      tick();
      chk("single_rdn_low", rx_rdn, 0);
      chk("single_valid", m_valid, 1);
      chk("single_data", m_data, 8'h5A);
      chk("single_count", count, 1);
      rx_ready = 1'b0;
      tick();
      chk("single_rdn_high", rx_rdn, 1);
      tick();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("single_pop_count", count, 0);
      chk("single_pop_empty", empty, 1);

      // Fill and overrun
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      rx_data  = 8'hAA;
      rx_ready = 1'b1;
      tick();
      chk("ovr_rdn_low", rx_rdn, 0);
      chk("ovr_flag", overrun, 1);
      chk("ovr_drop", drop_cnt, 1);
      chk("ovr_count", count, 16);
      rx_ready = 1'b0;
      tick();
      chk("ovr_rdn_high", rx_rdn, 1);
      tick();
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_data", m_data, i);
         tick();
      end
      m_ready = 1'b0;
      chk("drain_empty", empty, 1);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      chk("clr_ovr", overrun, 0);
      chk("clr_drop", drop_cnt, 0);

      // Simultaneous push/pop at COUNT=3
      send_byte(8'h10);
      send_byte(8'h11);
      send_byte(8'h12);
      chk("pp3_pre", count, 3);
      rx_data  = 8'h13;
      rx_ready = 1'b1;
      m_ready  = 1'b1;
      tick();
      m_ready  = 1'b0;
      rx_ready = 1'b0;
      chk("pp3_count", count, 3);
      chk("pp3_head", m_data, 8'h11);
      tick();
      tick();
      m_ready = 1'b1;
      chk("pp3_d1", m_data, 8'h11);
      tick();
      chk("pp3_d2", m_data, 8'h12);
      tick();
      chk("pp3_d3", m_data, 8'h13);
      tick();
      m_ready = 1'b0;
      chk("pp3_empty", count, 0);

      // Simultaneous push/pop at FULL: push refused
      for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
      rx_data  = 8'hBB;
      rx_ready = 1'b1;
      m_ready  = 1'b1;
      tick();
      m_ready  = 1'b0;
      rx_ready = 1'b0;
      chk("ppf_count", count, 15);
      chk("ppf_drop", drop_cnt, 1);
      chk("ppf_head", m_data, 8'h21);
      tick();
      tick();
      m_ready = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      m_ready = 1'b0;
      chk("ppf_empty", empty, 1);
      chk("ppf_ovr_kept", overrun, 1);

      // Stuck ready: six cycles high, one push
      rx_data  = 8'h33;
      rx_ready = 1'b1;
      tick();
      chk("stuck_rdn_low", rx_rdn, 0);
      lows = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rx_rdn == 1'b0) lows++;
      end
      chk("stuck_extra_rdn", lows, 0);
      chk("stuck_count", count, 1);
      rx_ready = 1'b0;
      tick();
      tick();
      chk("stuck_count_after", count, 1);
      chk("stuck_data", m_data, 8'h33);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("stuck_drained", count, 0);

      // Reset during ACK with COUNT=5
      for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
      rx_data  = 8'h44;
      rx_ready = 1'b1;
      tick();
      chk("racк_pre_count", count, 5);
      chk("rack_pre_rdn", rx_rdn, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rack_rdn", rx_rdn, 1);
      chk("rack_count", count, 0);
      chk("rack_valid", m_valid, 0);
      chk("rack_ovr", overrun, 0);
      tick();
      chk("rack_recap_count", count, 1);
      chk("rack_recap_data", m_data, 8'h44);
      chk("rack_recap_rdn", rx_rdn, 0);
      rx_ready = 1'b0;
      tick();
      tick();
      chk("rack_once", count, 1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;

      // Counter saturation and clear-with-drop
      for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i));
      for (int i = 0; i < 300; i++) send_byte(8'hEE);
      chk("sat_drop", drop_cnt, 8'hFF);
      chk("sat_ovr", overrun, 1);
      chk("sat_count", count, 16);
      rx_data  = 8'hCC;
      rx_ready = 1'b1;
      clr_ovr  = 1'b1;
      tick();
      clr_ovr  = 1'b0;
      rx_ready = 1'b0;
      chk("clrdrop_ovr", overrun, 1);
      chk("clrdrop_cnt", drop_cnt, 1);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
